// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencer with 64x48 synchronous instruction memory; FETCH_PERF_CNT_EN builds the fetch/stall counters
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        imem_we,
  input  logic [5:0]  imem_waddr,
  input  logic [47:0] imem_wdata,
  output logic [31:0] pc_out,
  output logic [47:0] instr_out,
  output logic        instr_valid,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);
  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;
  state_t      state;
  logic [31:0] pc_reg;
  logic [47:0] imem [64];
  logic        advance;
  assign advance     = ~stall | redirect_valid;
  assign instr_valid = state == RUN;
  assign if_id_write = advance;
  assign if_id_flush = redirect_valid | (~instr_valid & ~stall);
  // load port; contents survive reset and reads see the pre-write value
  always_ff @(posedge clk)
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  // PC, FSM and registered fetch outputs; a redirect wins over stall and bubbles the bundle read on that edge
  always_ff @(posedge clk)
    if (reset) begin
      pc_reg    <= '0;
      state     <= BOOT;
      pc_out    <= '0;
      instr_out <= '0;
    end else if (advance) begin
      instr_out <= imem[pc_reg[5:0]];
      pc_out    <= pc_reg;
      pc_reg    <= redirect_valid ? redirect_pc : pc_reg + 32'd1;
      state     <= redirect_valid ? BUBBLE : RUN;
    end
`ifdef FETCH_PERF_CNT_EN
  // valid-bundle loads and stalled edges
  always_ff @(posedge clk)
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (advance && !redirect_valid) fetch_count <= fetch_count + 32'd1;
      if (stall && !redirect_valid) stall_count <= stall_count + 32'd1;
    end
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif
endmodule
